muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Request/result bundle between the pipeline and the HI/LO multiply/divide unit.
// The pipeline side drives start/op/operands/move-to writes; the unit returns status and HI/LO.
interface muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdat;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wdat,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdat,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// One shift-add or restoring-divide step per clock on operand magnitudes; signs are fixed up at FINISH.
module muldiv_unit (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  md
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] mag_q;
    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] hi_d;
    logic [31:0] lo_d;

    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic [32:0] div_diff;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        neg_a;
    logic        neg_b;

    // Magnitudes of the incoming operands, taken at the accept edge
    always_comb begin
        mag_a = (md.op[0] && md.a[31]) ? (~md.a + 32'd1) : md.a;
        mag_b = (md.op[0] && md.b[31]) ? (~md.b + 32'd1) : md.b;
    end

    // acc_q holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        acc_d    = acc_q;
        mul_sum  = '0;
        div_sh   = '0;
        div_diff = '0;
        if (!op_q[1]) begin
            mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_q} : 33'd0);
            acc_d   = {mul_sum, acc_q[31:1]};
        end else begin
            div_sh   = {acc_q[63:32], acc_q[31]};
            div_diff = div_sh - {1'b0, mag_q};
            if (!div_diff[32]) begin
                acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
            end else begin
                acc_d = {div_sh[31:0], acc_q[30:0], 1'b0};
            end
        end
    end

    always_comb begin
        neg_a = op_q[0] & a_q[31];
        neg_b = op_q[0] & b_q[31];
        prod  = (neg_a ^ neg_b) ? (~acc_q + 64'd1) : acc_q;
        quo   = acc_q[31:0];
        rem   = acc_q[63:32];
        hi_d  = prod[63:32];
        lo_d  = prod[31:0];
        if (op_q[1]) begin
            if (b_q == '0) begin
                hi_d = a_q;
                lo_d = '1;
            end else begin
                lo_d = (neg_a ^ neg_b) ? (~quo + 32'd1) : quo;
                hi_d = neg_a ? (~rem + 32'd1) : rem;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mag_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (md.mthi) hi_q <= md.wdat;
                    if (md.mtlo) lo_q <= md.wdat;
                    if (md.start) begin
                        op_q    <= md.op;
                        a_q     <= md.a;
                        b_q     <= md.b;
                        mag_q   <= md.op[1] ? mag_b : mag_a;
                        acc_q   <= {32'd0, (md.op[1] ? mag_a : mag_b)};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= FINISH;
                end
                FINISH: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md.busy = busy_q;
    assign md.done = done_q;
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule
